// File: rtl/riscv_checkpoint_monitor.sv
// Self-check stage behind RISCV_TOP: walks an ordered table of (instruction count,
// expected output) checkpoints while the core runs and reports pass/fail and cycle count.
module riscv_checkpoint_monitor #(
    parameter int          NUM_TEST = 40,
    parameter int          IDW      = 6,
    parameter logic [31:0] TIMEOUT  = 32'd1000000
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           CFG_WE,
    input  logic [IDW-1:0] CFG_IDX,
    input  logic [31:0]    CFG_NUM_INST,
    input  logic [31:0]    CFG_ANS,
    input  logic [IDW-1:0] CFG_COUNT,
    input  logic           START,
    input  logic [31:0]    NUM_INST,
    input  logic [31:0]    OUTPUT_PORT,
    input  logic           HALT,
    output logic           BUSY,
    output logic           DONE,
    output logic           PASS,
    output logic [2:0]     FAIL_CODE,
    output logic [IDW-1:0] FAIL_IDX,
    output logic [31:0]    FAIL_GOT,
    output logic           CHK_PULSE,
    output logic [IDW-1:0] CHK_IDX,
    output logic [31:0]    CYCLE
);

    localparam logic [IDW-1:0] NT_I     = IDW'(NUM_TEST);
    localparam logic [IDW-1:0] ONE_I    = IDW'(1);
    localparam logic [31:0]    TMO_LAST = TIMEOUT - 32'd1;

    localparam logic [2:0] F_NONE       = 3'd0;
    localparam logic [2:0] F_MISMATCH   = 3'd1;
    localparam logic [2:0] F_MISSED     = 3'd2;
    localparam logic [2:0] F_INCOMPLETE = 3'd3;
    localparam logic [2:0] F_TIMEOUT    = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state, state_n;

    logic [31:0]    tbl_num [NUM_TEST];
    logic [31:0]    tbl_ans [NUM_TEST];
    logic [IDW-1:0] ptr, cnt, cnt_start, ptr_n, idx_n;
    logic [2:0]     code_n;
    logic           in_range, hit, match, miss, finish;

    // Table is plain storage; it survives reset so a board can rerun without reloading.
    always_ff @(posedge CLK) begin
        if (CFG_WE && state != S_RUN && CFG_IDX < NT_I) begin
            tbl_num[CFG_IDX] <= CFG_NUM_INST;
            tbl_ans[CFG_IDX] <= CFG_ANS;
        end
    end

    always_comb begin
        cnt_start = (CFG_COUNT > NT_I) ? NT_I : CFG_COUNT;
    end

    // One RUN evaluation: checkpoint step first, then HALT on the advanced pointer, then timeout.
    always_comb begin
        in_range = ptr < cnt;
        hit      = in_range && (NUM_INST == tbl_num[ptr]);
        match    = hit && (OUTPUT_PORT == tbl_ans[ptr]);
        miss     = in_range && (NUM_INST > tbl_num[ptr]);
        ptr_n    = match ? ptr + ONE_I : ptr;
        code_n   = F_NONE;
        idx_n    = ptr_n;
        if (hit && !match) begin
            code_n = F_MISMATCH;
            idx_n  = ptr;
        end else if (miss) begin
            code_n = F_MISSED;
            idx_n  = ptr;
        end else if (HALT) begin
            code_n = (ptr_n == cnt) ? F_NONE : F_INCOMPLETE;
        end else if (CYCLE == TMO_LAST) begin
            code_n = F_TIMEOUT;
        end
        finish = (code_n != F_NONE) || HALT;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (START)  state_n = S_RUN;
            S_RUN:   if (finish) state_n = S_DONE;
            S_DONE:  if (START)  state_n = S_RUN;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state == S_RUN);
        DONE = (state == S_DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr       <= '0;
            cnt       <= '0;
            PASS      <= 1'b0;
            FAIL_CODE <= F_NONE;
            FAIL_IDX  <= '0;
            FAIL_GOT  <= '0;
            CHK_PULSE <= 1'b0;
            CHK_IDX   <= '0;
            CYCLE     <= '0;
        end else begin
            CHK_PULSE <= 1'b0;
            if (state == S_RUN) begin
                ptr <= ptr_n;
                if (match) begin
                    CHK_PULSE <= 1'b1;
                    CHK_IDX   <= ptr;
                end
                if (finish) begin
                    PASS      <= (code_n == F_NONE);
                    FAIL_CODE <= code_n;
                    if (code_n != F_NONE) begin
                        FAIL_IDX <= idx_n;
                        FAIL_GOT <= OUTPUT_PORT;
                    end
                end else begin
                    CYCLE <= CYCLE + 32'd1;
                end
            end else if (START) begin
                ptr       <= '0;
                cnt       <= cnt_start;
                PASS      <= 1'b0;
                FAIL_CODE <= F_NONE;
                FAIL_IDX  <= '0;
                FAIL_GOT  <= '0;
                CYCLE     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_riscv_checkpoint_monitor.sv
// Bench for riscv_checkpoint_monitor: table-driven scoreboard runs plus hand-written
// timeout, async-reset and stall sequences.
module tb_riscv_checkpoint_monitor;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CFG_WE = 1'b0;
    logic [5:0]  CFG_IDX = '0;
    logic [31:0] CFG_NUM_INST = '0;
    logic [31:0] CFG_ANS = '0;
    logic [5:0]  CFG_COUNT = '0;
    logic        START = 1'b0;
    logic [31:0] NUM_INST = '0;
    logic [31:0] OUTPUT_PORT = '0;
    logic        HALT = 1'b0;
    logic        BUSY, DONE, PASS, CHK_PULSE;
    logic [2:0]  FAIL_CODE;
    logic [5:0]  FAIL_IDX, CHK_IDX;
    logic [31:0] FAIL_GOT, CYCLE;

    int n_cmp = 0;
    int n_fail = 0;

    riscv_checkpoint_monitor #(.NUM_TEST(40), .IDW(6), .TIMEOUT(32'd16)) dut (
        .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX),
        .CFG_NUM_INST(CFG_NUM_INST), .CFG_ANS(CFG_ANS), .CFG_COUNT(CFG_COUNT),
        .START(START), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .FAIL_CODE(FAIL_CODE),
        .FAIL_IDX(FAIL_IDX), .FAIL_GOT(FAIL_GOT), .CHK_PULSE(CHK_PULSE),
        .CHK_IDX(CHK_IDX), .CYCLE(CYCLE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          start;
        logic [5:0]  count;
        logic [31:0] num;
        logic [31:0] outp;
        bit          halt;
        bit          e_busy;
        bit          e_done;
        bit          e_pass;
        logic [2:0]  e_code;
        logic [5:0]  e_idx;
        logic [31:0] e_got;
        bit          e_pulse;
        logic [5:0]  e_chk;
    } vec_t;

    vec_t vt[$];
    vec_t sb[$];

    function automatic vec_t mk(bit st, logic [5:0] cc, logic [31:0] n, logic [31:0] o, bit h,
                                bit eb, bit ed, bit ep, logic [2:0] ec, logic [5:0] ei,
                                logic [31:0] eg, bit epl, logic [5:0] eci);
        vec_t v;
        v.start = st;  v.count = cc;  v.num = n;  v.outp = o;  v.halt = h;
        v.e_busy = eb; v.e_done = ed; v.e_pass = ep; v.e_code = ec; v.e_idx = ei;
        v.e_got = eg;  v.e_pulse = epl; v.e_chk = eci;
        return v;
    endfunction

    function automatic vec_t vs(logic [5:0] cc);
        return mk(1'b1, cc, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 6'd0, 32'd0, 1'b0, 6'd0);
    endfunction

    function automatic vec_t vr(logic [31:0] n, logic [31:0] o, bit h, bit epl, logic [5:0] eci);
        return mk(1'b0, 6'd0, n, o, h, 1'b1, 1'b0, 1'b0, 3'd0, 6'd0, 32'd0, epl, eci);
    endfunction

    function automatic vec_t vd(logic [31:0] n, logic [31:0] o, bit h, bit ep, logic [2:0] ec,
                                logic [5:0] ei, logic [31:0] eg, bit epl, logic [5:0] eci);
        return mk(1'b0, 6'd0, n, o, h, 1'b0, 1'b1, ep, ec, ei, eg, epl, eci);
    endfunction

    // Expected table contents: 4 -> 0x0f00, 6 -> 0x0018, 8 -> 0x001d
    function automatic logic [31:0] ans_of(int n);
        case (n)
            4:       return 32'h0f00;
            6:       return 32'h0018;
            8:       return 32'h001d;
            default: return 32'h0000;
        endcase
    endfunction

    function automatic bit pl(int n);
        return (n == 4) || (n == 6) || (n == 8);
    endfunction

    function automatic logic [5:0] ci(int n);
        return 6'((n - 4) / 2);
    endfunction

    function automatic logic [50:0] snap(bit b, bit d, bit p, logic [2:0] c, logic [5:0] fi,
                                         bit pu, logic [5:0] chk, logic [31:0] g,
                                         bit use_chk, bit use_got);
        return {b, d, p, c, fi, pu, (use_chk ? chk : 6'd0), (use_got ? g : 32'd0)};
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_write(logic [5:0] idx, logic [31:0] n, logic [31:0] a);
        CFG_WE = 1'b1; CFG_IDX = idx; CFG_NUM_INST = n; CFG_ANS = a;
        tick();
        CFG_WE = 1'b0;
    endtask

    task automatic start_run(logic [5:0] cc);
        START = 1'b1; CFG_COUNT = cc;
        tick();
        START = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        int   k;
        int   pulses;

        // Scenario: full pass, HALT after last checkpoint, then hold in DONE
        vt.push_back(vs(6'd3));
        for (int n = 0; n <= 8; n++) vt.push_back(vr(32'(n), ans_of(n), 1'b0, pl(n), ci(n)));
        vt.push_back(vd(32'd9, 32'd0, 1'b1, 1'b1, 3'd0, 6'd0, 32'd0, 1'b0, 6'd0));
        vt.push_back(vd(32'd9, 32'd0, 1'b0, 1'b1, 3'd0, 6'd0, 32'd0, 1'b0, 6'd0));
        // Scenario: wrong value at checkpoint 1
        vt.push_back(vs(6'd3));
        for (int n = 0; n <= 5; n++) vt.push_back(vr(32'(n), ans_of(n), 1'b0, pl(n), ci(n)));
        vt.push_back(vd(32'd6, 32'h17, 1'b0, 1'b0, 3'd1, 6'd1, 32'h17, 1'b0, 6'd0));
        // Scenario: NUM_INST skips checkpoint 1
        vt.push_back(vs(6'd3));
        for (int n = 0; n <= 5; n++) vt.push_back(vr(32'(n), ans_of(n), 1'b0, pl(n), ci(n)));
        vt.push_back(vd(32'd7, 32'h1234, 1'b0, 1'b0, 3'd2, 6'd1, 32'h1234, 1'b0, 6'd0));
        // Scenario: HALT coincident with last matching checkpoint
        vt.push_back(vs(6'd3));
        vt.push_back(vr(32'd0, 32'd0, 1'b0, 1'b0, 6'd0));
        vt.push_back(vr(32'd4, 32'h0f00, 1'b0, 1'b1, 6'd0));
        vt.push_back(vr(32'd6, 32'h0018, 1'b0, 1'b1, 6'd1));
        vt.push_back(vd(32'd8, 32'h001d, 1'b1, 1'b1, 3'd0, 6'd0, 32'd0, 1'b1, 6'd2));
        // Scenario: HALT too early -> incomplete
        vt.push_back(vs(6'd3));
        vt.push_back(vr(32'd4, 32'h0f00, 1'b0, 1'b1, 6'd0));
        vt.push_back(vd(32'd6, 32'h0018, 1'b1, 1'b0, 3'd3, 6'd2, 32'd0, 1'b1, 6'd1));
        // Scenario: mismatch wins over simultaneous HALT
        vt.push_back(vs(6'd3));
        vt.push_back(vr(32'd4, 32'h0f00, 1'b0, 1'b1, 6'd0));
        vt.push_back(vd(32'd6, 32'h17, 1'b1, 1'b0, 3'd1, 6'd1, 32'h17, 1'b0, 6'd0));
        // Scenario: empty table, HALT passes with no checks
        vt.push_back(vs(6'd0));
        vt.push_back(vr(32'd100, 32'd0, 1'b0, 1'b0, 6'd0));
        vt.push_back(vr(32'd4, 32'h0f00, 1'b0, 1'b0, 6'd0));
        vt.push_back(vd(32'd5, 32'd0, 1'b1, 1'b1, 3'd0, 6'd0, 32'd0, 1'b0, 6'd0));

        // Reset state (asynchronous, before any clock edge)
        #1;
        check("reset_outputs", {BUSY, DONE, PASS, FAIL_CODE, FAIL_IDX, FAIL_GOT, CHK_PULSE, CHK_IDX, CYCLE},
              64'd0);
        tick();
        tick();
        RST = 1'b0;
        cfg_write(6'd0, 32'd4, 32'h0f00);
        cfg_write(6'd1, 32'd6, 32'h0018);
        cfg_write(6'd2, 32'd8, 32'h001d);
        check("idle_after_cfg", {BUSY, DONE}, 64'd0);

        for (int i = 0; i < vt.size(); i++) begin
            START = vt[i].start; CFG_COUNT = vt[i].count;
            NUM_INST = vt[i].num; OUTPUT_PORT = vt[i].outp; HALT = vt[i].halt;
            sb.push_back(vt[i]);
            tick();
            START = 1'b0;
            e = sb.pop_front();
            check($sformatf("vec%0d", i),
                  64'(snap(BUSY, DONE, PASS, FAIL_CODE, FAIL_IDX, CHK_PULSE, CHK_IDX, FAIL_GOT,
                           e.e_pulse, (e.e_code == 3'd1) || (e.e_code == 3'd2))),
                  64'(snap(e.e_busy, e.e_done, e.e_pass, e.e_code, e.e_idx, e.e_pulse, e.e_chk, e.e_got,
                           e.e_pulse, (e.e_code == 3'd1) || (e.e_code == 3'd2))));
        end
        HALT = 1'b0;

        // Timeout: NUM_INST stuck at 0, no HALT
        NUM_INST = 32'd0; OUTPUT_PORT = 32'd0;
        start_run(6'd3);
        check("tmo_started", {BUSY, CYCLE}, {1'b1, 32'd0});
        k = 0;
        while (!DONE && k < 40) begin
            tick();
            k++;
        end
        check("tmo_run_cycles", 64'(k), 64'd16);
        check("tmo_result", {DONE, PASS, FAIL_CODE, FAIL_IDX, CYCLE}, {1'b1, 1'b0, 3'd4, 6'd0, 32'd15});
        tick();
        tick();
        tick();
        check("tmo_frozen", {DONE, CYCLE}, {1'b1, 32'd15});
        start_run(6'd3);
        check("restart_clear", {BUSY, DONE, FAIL_CODE, CYCLE}, {1'b1, 1'b0, 3'd0, 32'd0});

        // Async reset mid-RUN with ptr=2
        NUM_INST = 32'd4; OUTPUT_PORT = 32'h0f00;
        tick();
        NUM_INST = 32'd6; OUTPUT_PORT = 32'h0018;
        tick();
        check("pre_reset", {BUSY, CHK_PULSE, CHK_IDX}, {1'b1, 1'b1, 6'd1});
        #3;
        RST = 1'b1;
        #1;
        check("async_reset", {BUSY, DONE, PASS, FAIL_CODE, FAIL_IDX, FAIL_GOT, CHK_PULSE, CHK_IDX, CYCLE},
              64'd0);
        tick();
        RST = 1'b0;
        NUM_INST = 32'd4; OUTPUT_PORT = 32'h0f00;
        start_run(6'd3);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (CHK_PULSE) begin
                pulses++;
                check("stall_idx", 64'(CHK_IDX), 64'd0);
            end
        end
        check("stall_pulses", 64'(pulses), 64'd1);

        // Table write while RUN must be ignored
        CFG_WE = 1'b1; CFG_IDX = 6'd1; CFG_NUM_INST = 32'd6; CFG_ANS = 32'hdead;
        tick();
        CFG_WE = 1'b0;
        NUM_INST = 32'd6; OUTPUT_PORT = 32'h0018;
        tick();
        check("run_write_ignored", {BUSY, CHK_PULSE, CHK_IDX}, {1'b1, 1'b1, 6'd1});
        NUM_INST = 32'd8; OUTPUT_PORT = 32'h001d; HALT = 1'b1;
        tick();
        HALT = 1'b0;
        check("final_pass", {DONE, PASS, FAIL_CODE}, {1'b1, 1'b1, 3'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
